// File: rtl/fft_pkg.sv
// Shared FFT datapath types: sign-magnitude and two's complement samples,
// default frame geometry, and a saturating counter helper.
package fft_pkg;

    localparam int FFT_WIDTH     = 16;
    localparam int FFT_FRAME_LEN = 16;

    typedef struct packed {
        logic                   sign;
        logic [FFT_WIDTH-2:0]   mag;
    } sm_t;

    typedef struct packed {
        sm_t re;
        sm_t im;
    } cplx_sm_t;

    typedef struct packed {
        logic [FFT_WIDTH-1:0] re;
        logic [FFT_WIDTH-1:0] im;
    } cplx_tc_t;

    // 8-bit add of a small increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_add8(
        input logic [7:0] a,
        input logic [1:0] b
    );
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/fixed_point_sm_to_tc.sv
// Single-component sign-magnitude to two's complement converter.
// Ports: sm_i (sign-magnitude in), tc_o (two's complement out),
//        neg_zero_o (input was sign=1 with zero magnitude).
module fixed_point_sm_to_tc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] sm_i,
    output logic [WIDTH-1:0] tc_o,
    output logic             neg_zero_o
);

    logic [WIDTH-1:0] mag;

    assign mag = {1'b0, sm_i[WIDTH-2:0]};

    // Negating a zero magnitude yields zero, so negative zero folds to 0
    // and the most-negative code can never appear.
    assign tc_o = sm_i[WIDTH-1] ? (~mag + WIDTH'(1)) : mag;

    assign neg_zero_o = sm_i[WIDTH-1] && (sm_i[WIDTH-2:0] == '0);

endmodule

// File: rtl/fixed_point_sm_to_tc_stream.sv
// Two-stage valid/ready stream converting complex sign-magnitude samples
// to two's complement, with frame-end marker and negative-zero counter.
// Ports: clk, n_rst (sync active-low), clear (sync flush),
//        in_valid/in_ready/in_re/in_im (sign-magnitude input stream),
//        out_valid/out_ready/out_re/out_im/out_last (two's complement output),
//        neg_zero_cnt (saturating count of negative-zero components).
module fixed_point_sm_to_tc_stream
    import fft_pkg::*;
#(
    parameter int WIDTH     = FFT_WIDTH,
    parameter int FRAME_LEN = FFT_FRAME_LEN
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_last,
    output logic [7:0]       neg_zero_cnt
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_re_q, s1_re_d;
    logic [WIDTH-1:0] s1_im_q, s1_im_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_re_q, s2_re_d;
    logic [WIDTH-1:0] s2_im_q, s2_im_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       nz_q, nz_d;

    logic             s2_load;
    logic             out_hs;
    logic [WIDTH-1:0] conv_re, conv_im;
    logic             nz_re, nz_im;

    fixed_point_sm_to_tc #(.WIDTH(WIDTH)) u_conv_re (
        .sm_i       (s1_re_q),
        .tc_o       (conv_re),
        .neg_zero_o (nz_re)
    );

    fixed_point_sm_to_tc #(.WIDTH(WIDTH)) u_conv_im (
        .sm_i       (s1_im_q),
        .tc_o       (conv_im),
        .neg_zero_o (nz_im)
    );

    // Stage 2 frees up when empty or when the consumer takes its sample;
    // stage 1 may then load because its content moves on at the same edge.
    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = n_rst && !clear && (!s1_valid_q || s2_load);
    assign out_hs   = s2_valid_q && out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_re_d    = s1_re_q;
        s1_im_d    = s1_im_q;
        s2_valid_d = s2_valid_q;
        s2_re_d    = s2_re_q;
        s2_im_d    = s2_im_q;
        cnt_d      = cnt_q;
        nz_d       = nz_q;

        if (clear) begin
            // Data registers keep their values; only the state is flushed
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            cnt_d      = '0;
            nz_d       = '0;
        end else begin
            if (in_ready) begin
                s1_valid_d = in_valid;
                if (in_valid) begin
                    s1_re_d = in_re;
                    s1_im_d = in_im;
                end
            end

            if (s2_load) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_re_d = conv_re;
                    s2_im_d = conv_im;
                    nz_d    = sat_add8(nz_q, {1'b0, nz_re} + {1'b0, nz_im});
                end
            end

            if (out_hs) begin
                cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            s1_valid_q <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_re_q    <= '0;
            s2_im_q    <= '0;
            cnt_q      <= '0;
            nz_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_re_q    <= s1_re_d;
            s1_im_q    <= s1_im_d;
            s2_valid_q <= s2_valid_d;
            s2_re_q    <= s2_re_d;
            s2_im_q    <= s2_im_d;
            cnt_q      <= cnt_d;
            nz_q       <= nz_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_re       = s2_re_q;
    assign out_im       = s2_im_q;
    assign out_last     = s2_valid_q && (cnt_q == LAST_IDX);
    assign neg_zero_cnt = nz_q;

endmodule

// File: tb/tb_fixed_point_sm_to_tc_stream.sv
// Testbench for fixed_point_sm_to_tc_stream: directed literal cases plus
// randomized traffic checked against a queue-based reference model.
module tb_fixed_point_sm_to_tc_stream;

    localparam int W  = 16;
    localparam int FL = 16;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [W-1:0] in_re, in_im;
    logic        out_valid;
    logic        out_ready;
    logic [W-1:0] out_re, out_im;
    logic        out_last;
    logic [7:0]  neg_zero_cnt;

    always #5 clk = ~clk;

    fixed_point_sm_to_tc_stream #(.WIDTH(W), .FRAME_LEN(FL)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_re        (in_re),
        .in_im        (in_im),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_re       (out_re),
        .out_im       (out_im),
        .out_last     (out_last),
        .neg_zero_cnt (neg_zero_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [W-1:0] q_re[$];
    logic [W-1:0] q_im[$];
    int fc = 0;
    int nzm = 0;
    int hs_idx = 0;
    int lastq[$];

    bit prev_flush = 0;
    bit prev_rst = 0;
    bit prev_hold = 0;
    logic [W-1:0] prev_re, prev_im;
    logic prev_last;

    bit drv_acc;

    function automatic int sm_val(input logic [W-1:0] v);
        int m;
        m = int'(v[W-2:0]);
        return v[W-1] ? -m : m;
    endfunction

    function automatic int nz_of(input logic [W-1:0] v);
        return (v[W-1] && v[W-2:0] == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare process: sees settled inputs/outputs for the coming edge
    always @(negedge clk) begin
        logic [W-1:0] r, i;
        bit acc, hs;
        if (prev_flush) begin
            chk("flush_valid", int'(out_valid), 0);
            chk("flush_nz", int'(neg_zero_cnt), 0);
            chk("flush_last", int'(out_last), 0);
            if (prev_rst) begin
                chk("rst_re", int'(out_re), 0);
                chk("rst_im", int'(out_im), 0);
            end
        end else if (prev_hold) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_re", int'(out_re), int'(prev_re));
            chk("hold_im", int'(out_im), int'(prev_im));
            chk("hold_last", int'(out_last), int'(prev_last));
        end

        if (!n_rst || clear) begin
            chk("flush_in_ready", int'(in_ready), 0);
            q_re.delete();
            q_im.delete();
            fc = 0;
            nzm = 0;
            hs_idx = 0;
            prev_flush = 1;
            prev_rst = !n_rst;
            prev_hold = 0;
        end else begin
            prev_flush = 0;
            prev_rst = 0;
            chk("in_ready", int'(in_ready),
                (q_re.size() < 2 || out_ready) ? 1 : 0);
            if (q_re.size() == 0) begin
                chk("idle_valid", int'(out_valid), 0);
                chk("nz_cnt", int'(neg_zero_cnt), nzm);
            end
            if (q_re.size() == 2) chk("full_valid", int'(out_valid), 1);
            if (!out_valid) chk("idle_last", int'(out_last), 0);

            acc = in_valid && in_ready;
            hs = out_valid && out_ready;
            if (hs) begin
                if (q_re.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    r = q_re.pop_front();
                    i = q_im.pop_front();
                    chk("out_re", int'($signed(out_re)), sm_val(r));
                    chk("out_im", int'($signed(out_im)), sm_val(i));
                    chk("no_min_re", (out_re == 16'h8000) ? 1 : 0, 0);
                    chk("out_last", int'(out_last), (fc == FL - 1) ? 1 : 0);
                    hs_idx++;
                    if (out_last) lastq.push_back(hs_idx);
                    fc = (fc + 1) % FL;
                end
            end
            if (acc) begin
                q_re.push_back(in_re);
                q_im.push_back(in_im);
                nzm = nzm + nz_of(in_re) + nz_of(in_im);
                if (nzm > 255) nzm = 255;
            end
            prev_hold = out_valid && !out_ready;
            prev_re = out_re;
            prev_im = out_im;
            prev_last = out_last;
        end
    end

    task automatic tick();
        #2;
        drv_acc = in_valid && in_ready && n_rst && !clear;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        lastq.delete();
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((q_re.size() != 0 || out_valid) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("drain_timeout", 1, 0);
    endtask

    function automatic logic [W-1:0] rnd_sm();
        logic [31:0] r;
        r = $urandom;
        if (r[3:2] == 2'b00) return {r[31], 15'h0};
        return r[W-1+8:8];
    endfunction

    task automatic direct(input logic [W-1:0] re, input logic [W-1:0] im,
                          input logic [W-1:0] er, input logic [W-1:0] ei);
        in_valid = 1'b1;
        in_re = re;
        in_im = im;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_early", int'(out_valid), 0);
        tick();
        chk("lat_valid", int'(out_valid), 1);
        chk("lit_re", int'(out_re), int'(er));
        chk("lit_im", int'(out_im), int'(ei));
        chk("lit_last", int'(out_last), 0);
    endtask

    task automatic midframe(input bit use_rst);
        int n, sent;
        do_reset();
        in_valid = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (hs_idx < 5 && n < 40) begin
            in_re = 16'h8000;
            in_im = rnd_sm();
            tick();
            n++;
        end
        if (n >= 40) chk("mid_timeout", 1, 0);
        chk("mid_pre_valid", int'(out_valid), 1);
        chk("mid_pre_nz_nonzero", (neg_zero_cnt != 0) ? 1 : 0, 1);
        if (use_rst) n_rst = 1'b0;
        else clear = 1'b1;
        tick();
        n_rst = 1'b1;
        clear = 1'b0;
        chk("mid_valid", int'(out_valid), 0);
        chk("mid_nz", int'(neg_zero_cnt), 0);
        lastq.delete();
        sent = 0;
        n = 0;
        while (sent < 16 && n < 100) begin
            in_valid = 1'b1;
            in_re = rnd_sm();
            in_im = rnd_sm();
            tick();
            if (drv_acc) sent++;
            n++;
        end
        drain();
        chk("mid_last_cnt", lastq.size(), 1);
        if (lastq.size() > 0) chk("mid_last_pos", lastq[0], 16);
    endtask

    initial begin
        int sent, n;
        n_rst = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
        out_ready = 1'b1;
        do_reset();

        // Literal conversions
        direct(16'h0005, 16'h8005, 16'h0005, 16'hFFFB);
        direct(16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h8001);
        direct(16'h8000, 16'h0000, 16'h0000, 16'h0000);
        chk("lit_nz1", int'(neg_zero_cnt), 1);
        drain();

        // Backpressure: 4 samples, consumer stalls 5 cycles after first out
        do_reset();
        sent = 0;
        n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 10) begin
            in_valid = (sent < 4);
            in_re = rnd_sm();
            in_im = rnd_sm();
            tick();
            if (drv_acc) sent++;
            n++;
        end
        out_ready = 1'b0;
        repeat (5) begin
            in_valid = (sent < 4);
            in_re = rnd_sm();
            in_im = rnd_sm();
            tick();
            if (drv_acc) sent++;
        end
        #1;
        chk("bp_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        n = 0;
        while (sent < 4 && n < 20) begin
            in_valid = 1'b1;
            in_re = rnd_sm();
            in_im = rnd_sm();
            tick();
            if (drv_acc) sent++;
            n++;
        end
        drain();
        chk("bp_count", hs_idx, 4);

        // Framing: 32 back-to-back samples
        do_reset();
        sent = 0;
        n = 0;
        while (sent < 32 && n < 100) begin
            in_valid = 1'b1;
            in_re = rnd_sm();
            in_im = rnd_sm();
            tick();
            if (drv_acc) sent++;
            n++;
        end
        drain();
        chk("frame_lasts", lastq.size(), 2);
        if (lastq.size() == 2) begin
            chk("frame_last0", lastq[0], 16);
            chk("frame_last1", lastq[1], 32);
        end

        // Saturation of the negative-zero counter
        do_reset();
        sent = 0;
        n = 0;
        while (sent < 130 && n < 300) begin
            in_valid = 1'b1;
            in_re = 16'h8000;
            in_im = 16'h8000;
            tick();
            if (drv_acc) sent++;
            n++;
        end
        drain();
        chk("sat_255", int'(neg_zero_cnt), 255);
        sent = 0;
        n = 0;
        while (sent < 3 && n < 20) begin
            in_valid = 1'b1;
            tick();
            if (drv_acc) sent++;
            n++;
        end
        drain();
        chk("sat_stays", int'(neg_zero_cnt), 255);

        // Flush mid-frame, by clear and by reset
        midframe(1'b0);
        midframe(1'b1);

        // Random traffic with occasional clears
        do_reset();
        repeat (2000) begin
            in_valid = ($urandom % 4) != 0;
            in_re = rnd_sm();
            in_im = rnd_sm();
            out_ready = ($urandom % 10) < 7;
            clear = ($urandom % 100) == 0;
            tick();
        end
        clear = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
